ibus_axi_bridge: RTL and testbench
==================================

// Module: ibus_axi_bridge
// PURPOSE
//  Responder end of the instruction bus driven by the instruction MMU: takes ibus_en/ibus_paddr,
//  performs a single-beat AXI4 read, returns ibus_rdata and holds the pipeline via ibus_stallreq.
//  Sits between the instruction MMU and the SoC AXI interconnect (read channels only).
// PARAMETERS
//  AXI_ID    4'h0   constant ARID; RID is not checked (single outstanding read)
//  ID_W      4      ARID/RID width
// PORTS
//  aclk          in   1        single clock, all logic rising-edge
//  aresetn       in   1        asynchronous, active-low reset
//  ibus_en       in   1        fetch request (held with paddr while ibus_stallreq=1)
//  ibus_paddr    in   32       physical word address (`AddrBus)
//  ibus_rdata    out  32       fetched word (`DataBus), valid when ibus_en=1 and ibus_stallreq=0
//  ibus_stallreq out  1        1 = current fetch not yet satisfied
//  ibus_buserr   out  1        1 with returned data when RRESP != OKAY
//  buf_flush     in   1        invalidate reuse buffer (ignored without IBUS_REUSE_EN)
//  arid          out  ID_W     = AXI_ID
//  araddr        out  32       registered request address, low 2 bits forced 0
//  arlen/arsize/arburst out 8/3/2  = 8'd0 / 3'b010 / 2'b01 (INCR)
//  arvalid       out  1        ; arready in 1
//  rid in ID_W; rdata in 32; rresp in 2; rlast in 1; rvalid in 1; rready out 1
// BEHAVIOUR
//  Reset: state=IDLE, arvalid=0, rready=0, araddr=0, rbuf=0, ibus_buserr=0, buf_valid=0.
//  States (local encoding): IDLE, AR, R, DONE.
//   IDLE: ibus_en=1 (and no reuse hit) -> latch paddr into req_addr, -> AR. ibus_en=0 -> stay.
//   AR:   arvalid=1, araddr=req_addr; arready=1 -> R. arvalid never drops before arready.
//   R:    rready=1; rvalid=1 -> rbuf<=rdata, err<=(rresp!=2'b00), -> DONE. rlast ignored (len 0).
//   DONE: rbuf presented one cycle; -> IDLE unconditionally.
//  ibus_stallreq = ibus_en & ~(state==DONE & ibus_paddr==req_addr) [& ~reuse_hit]; 0 when ibus_en=0.
//  ibus_rdata = rbuf in DONE (or reuse hit), else 32'h0. ibus_buserr = err only while data returned.
//  Minimum latency: request seen cycle 0 -> arvalid cycle 1 -> rvalid earliest cycle 2 -> data cycle 3.
//  Address change while in AR/R (branch/exception redirect): AXI read completes, data captured, DONE
//   mismatches -> stall held, DONE->IDLE -> refetch new address. No AXI abort.
//  ibus_en dropped mid-transaction: transaction completes and is discarded; no stall output.
//  Simultaneous arready and rvalid in AR: rvalid ignored (rready=0 in AR).
//  Async reset mid-transaction: immediate return to IDLE; interconnect shares the reset.
//  Back-to-back: next request accepted in IDLE the cycle after DONE (1 bubble per fetch).
// CONFIGURATION
//  IBUS_REUSE_EN defined: one-entry buffer {buf_valid, buf_addr, buf_data}, loaded at DONE on OKAY.
//   IDLE & ibus_en & buf_valid & paddr==buf_addr -> reuse_hit: zero-latency data, stall=0, no AXI.
//   buf_valid cleared by reset, buf_flush (takes priority over same-cycle load), or error response.
//  Not defined: no buffer; every fetch issues an AXI read; buf_flush unconnected internally.
// STRUCTURE
//  Defines.v: `AddrBus/`DataBus, `true/`false, `ZeroWord, AXI encodings (AXI_SIZE_4B, AXI_BURST_INCR,
//   AXI_RESP_OKAY). State encodings stay local parameters.
//  Single module; no sub-module (reuse buffer is a few registers inside an `ifdef).
// TESTING
//  1 arready=1, rvalid 1 cycle after AR, paddr=0x1FC0_0000 -> araddr=0x1FC0_0000, data cycle 3, stall 0 then.
//  2 arready delayed 4 cycles -> arvalid/araddr stable throughout, stall=1 until DONE.
//  3 paddr 0x100 -> 0x200 while in R -> 0x100 data discarded, second AR to 0x200, data returned.
//  4 rresp=2'b10 on fetch 0x300 -> ibus_buserr=1 with data in DONE; buffer not loaded.
//  5 aresetn low while in R -> arvalid=0, rready=0, stall reflects IDLE next request after release.
//  6 IBUS_REUSE_EN: fetch 0x400 twice -> one AXI read, second stall=0; buf_flush then 0x400 -> new read.

Source files
------------

// File: rtl/ibus_axi_bridge_pkg.sv
// Shared bus widths and AXI4 encodings for the instruction-bus AXI read bridge.
package ibus_axi_bridge_pkg;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic              TRUE      = 1'b1;
  localparam logic              FALSE     = 1'b0;
  localparam logic [DATA_W-1:0] ZERO_WORD = '0;

  localparam logic [7:0] AXI_LEN_SINGLE = 8'd0;
  localparam logic [2:0] AXI_SIZE_4B    = 3'b010;
  localparam logic [1:0] AXI_BURST_INCR = 2'b01;
  localparam logic [1:0] AXI_RESP_OKAY  = 2'b00;

  function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
    return {addr[ADDR_W-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/ibus_axi_bridge.sv
// Instruction-bus responder issuing one single-beat AXI4 read per fetch.
// Optional one-entry fetch reuse buffer enabled by defining IBUS_REUSE_EN.
module ibus_axi_bridge
  import ibus_axi_bridge_pkg::*;
#(
  parameter int unsigned      ID_W   = 4,
  parameter logic [ID_W-1:0]  AXI_ID = '0
) (
  input  logic              aclk,
  input  logic              aresetn,

  input  logic              ibus_en,
  input  logic [ADDR_W-1:0] ibus_paddr,
  output logic [DATA_W-1:0] ibus_rdata,
  output logic              ibus_stallreq,
  output logic              ibus_buserr,
  input  logic              buf_flush,

  output logic [ID_W-1:0]   arid,
  output logic [ADDR_W-1:0] araddr,
  output logic [7:0]        arlen,
  output logic [2:0]        arsize,
  output logic [1:0]        arburst,
  output logic              arvalid,
  input  logic              arready,

  input  logic [ID_W-1:0]   rid,
  input  logic [DATA_W-1:0] rdata,
  input  logic [1:0]        rresp,
  input  logic              rlast,
  input  logic              rvalid,
  output logic              rready
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_AR   = 2'd1;
  localparam logic [1:0] S_R    = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  logic [1:0]        state;
  logic [ADDR_W-1:0] req_addr;
  logic [DATA_W-1:0] rbuf;
  logic              err;
  logic              reuse_hit;
  logic              done_match;

  assign arid    = AXI_ID;
  assign arlen   = AXI_LEN_SINGLE;
  assign arsize  = AXI_SIZE_4B;
  assign arburst = AXI_BURST_INCR;

  // Handshake strobes come straight from the state register, so arvalid holds until arready.
  assign arvalid = (state == S_AR);
  assign rready  = (state == S_R);

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state    <= S_IDLE;
      req_addr <= '0;
      araddr   <= '0;
      rbuf     <= '0;
      err      <= FALSE;
    end else begin
      case (state)
        S_IDLE: begin
          if (ibus_en && !reuse_hit) begin
            req_addr <= ibus_paddr;
            araddr   <= word_align(ibus_paddr);
            state    <= S_AR;
          end
        end
        S_AR: begin
          if (arready) state <= S_R;
        end
        S_R: begin
          if (rvalid) begin
            rbuf  <= rdata;
            err   <= (rresp != AXI_RESP_OKAY);
            state <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // A redirect during AR/R leaves req_addr stale; the mismatch keeps the stall up and forces a refetch.
  assign done_match = (state == S_DONE) && (ibus_paddr == req_addr);

`ifdef IBUS_REUSE_EN
  logic              buf_valid;
  logic [ADDR_W-1:0] buf_addr;
  logic [DATA_W-1:0] buf_data;
  logic              unused_resp;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      buf_valid <= FALSE;
      buf_addr  <= '0;
      buf_data  <= '0;
    end else if (buf_flush) begin
      buf_valid <= FALSE;
    end else if (state == S_DONE) begin
      if (err) begin
        buf_valid <= FALSE;
      end else begin
        buf_valid <= TRUE;
        buf_addr  <= req_addr;
        buf_data  <= rbuf;
      end
    end
  end

  assign reuse_hit = (state == S_IDLE) && ibus_en && buf_valid && (ibus_paddr == buf_addr);

  always_comb begin
    ibus_rdata = ZERO_WORD;
    if (state == S_DONE) ibus_rdata = rbuf;
    else if (reuse_hit)  ibus_rdata = buf_data;
  end

  assign unused_resp = ^{rid, rlast};
`else
  logic unused_resp;

  assign reuse_hit = FALSE;

  always_comb begin
    ibus_rdata = ZERO_WORD;
    if (state == S_DONE) ibus_rdata = rbuf;
  end

  assign unused_resp = ^{rid, rlast, buf_flush};
`endif

  assign ibus_stallreq = ibus_en && !done_match && !reuse_hit;
  assign ibus_buserr   = ibus_en && done_match && err;

endmodule

// File: tb/tb_ibus_axi_bridge.sv
// Directed bench for ibus_axi_bridge with a behavioural AXI read slave and a fetch scoreboard.
module tb_ibus_axi_bridge;

  logic        aclk = 1'b0;
  logic        aresetn;
  logic        ibus_en;
  logic [31:0] ibus_paddr;
  logic [31:0] ibus_rdata;
  logic        ibus_stallreq;
  logic        ibus_buserr;
  logic        buf_flush;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;

  always #5 aclk = ~aclk;

  ibus_axi_bridge #(.ID_W(4), .AXI_ID(4'h0)) dut (
    .aclk(aclk), .aresetn(aresetn),
    .ibus_en(ibus_en), .ibus_paddr(ibus_paddr), .ibus_rdata(ibus_rdata),
    .ibus_stallreq(ibus_stallreq), .ibus_buserr(ibus_buserr), .buf_flush(buf_flush),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready)
  );

  int n_assert = 0;
  int n_fail   = 0;

  // slave model state
  int          ar_delay = 0;
  int          r_delay  = 0;
  logic [1:0]  resp_cfg = 2'b00;
  int          ar_wait  = 0;
  int          r_wait   = 0;
  bit          pend     = 0;
  logic [31:0] pend_addr = '0;
  int          n_ar     = 0;
  logic [31:0] ar_log[$];
  logic [32:0] sb[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h5A5A_0F0F;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_assert++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic tick();
    logic ar_hs, r_hs, pv_arv, pv_ard;
    logic [31:0] pv_addr;
    ar_hs   = arvalid & arready;
    r_hs    = rvalid & rready;
    pv_arv  = arvalid;
    pv_ard  = arready;
    pv_addr = araddr;
    @(posedge aclk);
    #1;
    if (pv_arv && !pv_ard && aresetn)
      chk("ar_hold", {31'b0, arvalid, araddr}, {31'b0, 1'b1, pv_addr});
    if (ar_hs) begin
      n_ar++;
      ar_log.push_back(pv_addr);
      pend = 1; pend_addr = pv_addr; r_wait = 0;
    end
    if (r_hs) pend = 0;
    if (arvalid) begin
      arready = (ar_wait >= ar_delay);
      ar_wait++;
    end else begin
      arready = 1'b0; ar_wait = 0;
    end
    if (pend && r_wait >= r_delay) begin
      rvalid = 1'b1; rdata = mem_word(pend_addr); rresp = resp_cfg; rlast = 1'b1;
    end else begin
      rvalid = 1'b0; rdata = '0; rresp = 2'b00; rlast = 1'b0;
    end
    if (pend) r_wait++;
    #1;
  endtask

  task automatic fetch(input logic [31:0] a, input int exp_lat);
    int lat;
    logic [32:0] e;
    ibus_en = 1'b1;
    ibus_paddr = a;
    sb.push_back({resp_cfg != 2'b00, mem_word({a[31:2], 2'b00})});
    #1;
    lat = 0;
    while (ibus_stallreq && lat < 50) begin
      tick();
      lat++;
    end
    chk("fetch_timeout", 64'(ibus_stallreq), 64'd0);
    e = sb.pop_front();
    chk("rdata", 64'(ibus_rdata), 64'(e[31:0]));
    chk("buserr", 64'(ibus_buserr), 64'(e[32]));
    if (exp_lat >= 0) chk("latency", 64'(lat), 64'(exp_lat));
    ibus_en = 1'b0;
    #1;
    chk("buserr_noen", 64'(ibus_buserr), 64'd0);
    chk("stall_noen", 64'(ibus_stallreq), 64'd0);
    tick();
    chk("idle_rdata", 64'(ibus_rdata), 64'd0);
  endtask

  initial begin
    int base;
    logic [32:0] e;
    int lat;

    aresetn = 1'b0; ibus_en = 1'b0; ibus_paddr = '0; buf_flush = 1'b0;
    arready = 1'b0; rid = '0; rdata = '0; rresp = 2'b00; rlast = 1'b0; rvalid = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    chk("rst_arvalid", 64'(arvalid), 64'd0);
    chk("rst_rready", 64'(rready), 64'd0);
    chk("rst_araddr", 64'(araddr), 64'd0);
    chk("rst_stall", 64'(ibus_stallreq), 64'd0);
    chk("rst_buserr", 64'(ibus_buserr), 64'd0);
    chk("rst_rdata", 64'(ibus_rdata), 64'd0);
    chk("ar_const", {44'b0, arid, arlen, arsize, arburst}, {44'b0, 4'h0, 8'd0, 3'b010, 2'b01});
    aresetn = 1'b1;
    tick();

    // 1: minimum latency fetch
    ar_log.delete();
    fetch(32'h1FC0_0000, 3);
    chk("t1_araddr", 64'(ar_log[0]), 64'h1FC0_0000);
    fetch(32'h0000_0706, 3);
    chk("align_araddr", 64'(ar_log[1]), 64'h0000_0704);

    // 2: delayed arready
    ar_delay = 4;
    fetch(32'h0000_1234, 7);
    ar_delay = 0;

    // 3: redirect while in R
    ar_log.delete();
    base = n_ar;
    r_delay = 2;
    ibus_en = 1'b1; ibus_paddr = 32'h100;
    tick(); tick();
    chk("t3_in_r", 64'(rready), 64'd1);
    ibus_paddr = 32'h200;
    sb.push_back({1'b0, mem_word(32'h200)});
    #1;
    lat = 0;
    while (ibus_stallreq && lat < 50) begin tick(); lat++; end
    chk("t3_timeout", 64'(ibus_stallreq), 64'd0);
    e = sb.pop_front();
    chk("t3_rdata", 64'(ibus_rdata), 64'(e[31:0]));
    chk("t3_n_ar", 64'(n_ar - base), 64'd2);
    chk("t3_ar0", 64'(ar_log[0]), 64'h100);
    chk("t3_ar1", 64'(ar_log[1]), 64'h200);
    ibus_en = 1'b0;
    tick();
    r_delay = 0;

    // 4: error response, buffer must not hold it
    resp_cfg = 2'b10;
    fetch(32'h300, 3);
    resp_cfg = 2'b00;
    base = n_ar;
    fetch(32'h300, 3);
    chk("t4_refetch", 64'(n_ar - base), 64'd1);

    // 5: asynchronous reset in R
    r_delay = 5;
    ibus_en = 1'b1; ibus_paddr = 32'h500;
    tick(); tick();
    chk("t5_in_r", 64'(rready), 64'd1);
    aresetn = 1'b0;
    #1;
    chk("t5_arvalid", 64'(arvalid), 64'd0);
    chk("t5_rready", 64'(rready), 64'd0);
    chk("t5_stall", 64'(ibus_stallreq), 64'd1);
    pend = 0; rvalid = 1'b0;
    tick();
    aresetn = 1'b1;
    r_delay = 0;
    sb.push_back({1'b0, mem_word(32'h500)});
    lat = 0;
    while (ibus_stallreq && lat < 50) begin tick(); lat++; end
    chk("t5_timeout", 64'(ibus_stallreq), 64'd0);
    e = sb.pop_front();
    chk("t5_rdata", 64'(ibus_rdata), 64'(e[31:0]));
    chk("t5_latency", 64'(lat), 64'd3);
    ibus_en = 1'b0;
    tick();

    // ibus_en dropped mid-transaction
    base = n_ar;
    ibus_en = 1'b1; ibus_paddr = 32'h600;
    tick();
    ibus_en = 1'b0;
    #1;
    chk("drop_stall", 64'(ibus_stallreq), 64'd0);
    repeat (5) tick();
    chk("drop_n_ar", 64'(n_ar - base), 64'd1);
    chk("drop_idle", {62'b0, arvalid, rready}, 64'd0);

    // 6: repeated fetch of one address
    base = n_ar;
`ifdef IBUS_REUSE_EN
    fetch(32'h400, 3);
    fetch(32'h400, 0);
    chk("t6_reuse_n_ar", 64'(n_ar - base), 64'd1);
    buf_flush = 1'b1;
    tick();
    buf_flush = 1'b0;
    fetch(32'h400, 3);
    chk("t6_flush_n_ar", 64'(n_ar - base), 64'd2);
`else
    fetch(32'h400, 3);
    fetch(32'h400, 3);
    chk("t6_n_ar", 64'(n_ar - base), 64'd2);
`endif
    chk("sb_empty", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
